tc_tile_mac: RTL and testbench

//   Pipelined, handshaked tensor-core tile engine: C[MxN] = sum over beats of A[MxK]*B[KxN].

---
 rtl/tc_pkg.sv | 37 +++
 rtl/tc_tile_mac_if.sv | 32 +++
 rtl/tc_dot_lane.sv | 37 +++
 rtl/tc_tile_mac.sv | 99 +++++++++
 tb/tb_tc_tile_mac.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tc_pkg.sv
// Shared constants and index helpers for the tc_* tensor-core blocks.
package tc_pkg;

  localparam int TC_TILE_M    = 4;
  localparam int TC_TILE_K    = 8;
  localparam int TC_TILE_N    = 4;
  localparam int TC_DW_IN     = 8;
  localparam int TC_DW_ACC    = 32;
  localparam int TC_DW_OUT    = 16;
  localparam int TC_MAX_KSTEP = 16;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Element positions inside the flat operand/result buses.
  function automatic int a_idx(input int m, input int k, input int tile_k);
    return m * tile_k + k;
  endfunction

  function automatic int b_idx(input int n, input int k, input int tile_k);
    return n * tile_k + k;
  endfunction

  function automatic int c_idx(input int m, input int n, input int tile_n);
    return m * tile_n + n;
  endfunction

endpackage

// File: rtl/tc_tile_mac_if.sv
// Operand-beat / result-tile handshake bundle for tc_tile_mac.
interface tc_tile_mac_if import tc_pkg::*; #(
  parameter int TILE_M    = TC_TILE_M,
  parameter int TILE_K    = TC_TILE_K,
  parameter int TILE_N    = TC_TILE_N,
  parameter int DW_IN     = TC_DW_IN,
  parameter int DW_OUT    = TC_DW_OUT,
  parameter int MAX_KSTEP = TC_MAX_KSTEP
);
  localparam int KCNT_W = clog2(MAX_KSTEP + 1);

  logic                            in_valid;
  logic                            in_ready;
  logic                            in_last;
  logic [TILE_M*TILE_K*DW_IN-1:0]  in_a;
  logic [TILE_N*TILE_K*DW_IN-1:0]  in_b;
  logic                            out_valid;
  logic                            out_ready;
  logic [TILE_M*TILE_N*DW_OUT-1:0] out;
  logic [KCNT_W-1:0]               out_kcnt;

  modport master (
    output in_valid, in_last, in_a, in_b, out_ready,
    input  in_ready, out_valid, out, out_kcnt
  );

  modport slave (
    input  in_valid, in_last, in_a, in_b, out_ready,
    output in_ready, out_valid, out, out_kcnt
  );

endinterface

// File: rtl/tc_dot_lane.sv
// One (m,n) lane: TILE_K signed products (S1) then a registered adder tree (S2).
module tc_dot_lane import tc_pkg::*; #(
  parameter int TILE_K = TC_TILE_K,
  parameter int DW_IN  = TC_DW_IN,
  parameter int DW_ACC = TC_DW_ACC
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic [TILE_K-1:0][DW_IN-1:0]  a,
  input  logic [TILE_K-1:0][DW_IN-1:0]  b,
  output logic [DW_ACC-1:0]             sum
);
  localparam int PW = 2 * DW_IN;

  logic [TILE_K-1:0][PW-1:0] prod_d, prod_q;
  logic [DW_ACC-1:0]         tree;

  // Sign-extending both operands first makes the truncated unsigned product exact.
  always_comb begin
    for (int k = 0; k < TILE_K; k++)
      prod_d[k] = {{DW_IN{a[k][DW_IN-1]}}, a[k]} * {{DW_IN{b[k][DW_IN-1]}}, b[k]};
  end

  always_comb begin
    tree = '0;
    for (int k = 0; k < TILE_K; k++)
      tree = tree + {{(DW_ACC-PW){prod_q[k][PW-1]}}, prod_q[k]};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      prod_q <= prod_d;
      sum    <= tree;
    end
  end

endmodule

// File: rtl/tc_tile_mac.sv
// Pipelined tile MAC: C = sum of A*B over beats until in_last (or MAX_KSTEP beats).
// TC_SAT_EN: clamp output elements to DW_OUT signed range instead of truncating.
module tc_tile_mac import tc_pkg::*; #(
  parameter int TILE_M    = TC_TILE_M,
  parameter int TILE_K    = TC_TILE_K,
  parameter int TILE_N    = TC_TILE_N,
  parameter int DW_IN     = TC_DW_IN,
  parameter int DW_ACC    = TC_DW_ACC,
  parameter int DW_OUT    = TC_DW_OUT,
  parameter int MAX_KSTEP = TC_MAX_KSTEP
) (
  input logic         clk,
  input logic         reset,
  tc_tile_mac_if.slave bus
);
  localparam int NL     = TILE_M * TILE_N;
  localparam int KCNT_W = clog2(MAX_KSTEP + 1);

  logic                                en, accept, tile_close;
  logic [2:1]                          vld_pipe, last_pipe;
  logic [NL-1:0][TILE_K-1:0][DW_IN-1:0] lane_a, lane_b;
  logic [NL-1:0][DW_ACC-1:0]           lane_sum, acc_q, acc_nxt;
  logic [NL-1:0][DW_OUT-1:0]           out_q;
  logic [KCNT_W-1:0]                   cnt_q, cnt_nxt, kcnt_q;
  logic                                oval_q;

`ifdef TC_SAT_EN
  localparam logic [DW_ACC-1:0] SAT_MAX = {{(DW_ACC-DW_OUT+1){1'b0}}, {(DW_OUT-1){1'b1}}};
  localparam logic [DW_ACC-1:0] SAT_MIN = {{(DW_ACC-DW_OUT+1){1'b1}}, {(DW_OUT-1){1'b0}}};
`endif

  function automatic logic [DW_OUT-1:0] to_out(input logic [DW_ACC-1:0] v);
`ifdef TC_SAT_EN
    if ($signed(v) > $signed(SAT_MAX)) return SAT_MAX[DW_OUT-1:0];
    if ($signed(v) < $signed(SAT_MIN)) return SAT_MIN[DW_OUT-1:0];
    return v[DW_OUT-1:0];
`else
    return v[DW_OUT-1:0];
`endif
  endfunction

  // A held result tile stalls the whole pipe, so no beat is ever dropped.
  assign en           = !(oval_q && !bus.out_ready);
  assign bus.in_ready = en && reset;
  assign accept       = bus.in_valid && bus.in_ready;
  assign cnt_nxt      = cnt_q + KCNT_W'(1);
  assign tile_close   = last_pipe[2] || (cnt_nxt == KCNT_W'(MAX_KSTEP));

  for (genvar m = 0; m < TILE_M; m++) begin : g_m
    for (genvar n = 0; n < TILE_N; n++) begin : g_n
      localparam int C = c_idx(m, n, TILE_N);
      for (genvar k = 0; k < TILE_K; k++) begin : g_k
        assign lane_a[C][k] = bus.in_a[a_idx(m, k, TILE_K)*DW_IN +: DW_IN];
        assign lane_b[C][k] = bus.in_b[b_idx(n, k, TILE_K)*DW_IN +: DW_IN];
      end
      tc_dot_lane #(.TILE_K(TILE_K), .DW_IN(DW_IN), .DW_ACC(DW_ACC)) u_lane (
        .clk (clk),
        .en  (en),
        .a   (lane_a[C]),
        .b   (lane_b[C]),
        .sum (lane_sum[C])
      );
      assign acc_nxt[C] = acc_q[C] + lane_sum[C];
    end
  end

  // Closing a tile zeroes acc so the next beat starts fresh without a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      kcnt_q    <= '0;
      oval_q    <= 1'b0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[1], accept};
      last_pipe <= {last_pipe[1], bus.in_last};
      oval_q    <= vld_pipe[2] && tile_close;
      if (vld_pipe[2]) begin
        if (tile_close) begin
          for (int i = 0; i < NL; i++) out_q[i] <= to_out(acc_nxt[i]);
          kcnt_q <= cnt_nxt;
          acc_q  <= '0;
          cnt_q  <= '0;
        end else begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_nxt;
        end
      end
    end
  end

  assign bus.out_valid = oval_q;
  assign bus.out       = out_q;
  assign bus.out_kcnt  = kcnt_q;

endmodule

// File: tb/tb_tc_tile_mac.sv
// Directed bench for tc_tile_mac: reset, latency, back-to-back, back-pressure, forced close, output width.
module tb_tc_tile_mac;
  import tc_pkg::*;

  localparam int M = 4, K = 8, N = 4, DI = 8, DA = 32, DO = 16, MK = 16;
  localparam int NL = M * N, AW = M * K * DI, BW = N * K * DI, OW = NL * DO;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0, failures = 0, cyc = 0;
  int   exp_c[NL];
  int   t0;

  logic [OW-1:0] q_out[$];
  int            q_k[$];
  int            q_cyc[$];

  tc_tile_mac_if #(.TILE_M(M), .TILE_K(K), .TILE_N(N), .DW_IN(DI), .DW_OUT(DO), .MAX_KSTEP(MK)) bus();

  tc_tile_mac #(.TILE_M(M), .TILE_K(K), .TILE_N(N), .DW_IN(DI), .DW_ACC(DA), .DW_OUT(DO),
                .MAX_KSTEP(MK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (reset && bus.out_valid && bus.out_ready) begin
      q_out.push_back(bus.out);
      q_k.push_back(int'(bus.out_kcnt));
      q_cyc.push_back(cyc);
    end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DO-1:0] cvt(input longint v);
`ifdef TC_SAT_EN
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
`endif
    return v[DO-1:0];
  endfunction

  function automatic logic [OW-1:0] pack_exp();
    logic [OW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*DO +: DO] = cvt(longint'(exp_c[i]));
    return r;
  endfunction

  task automatic set_uniform(input int v);
    for (int i = 0; i < NL; i++) exp_c[i] = v;
  endtask

  function automatic logic [AW-1:0] uni_a(input int v);
    logic [AW-1:0] r;
    for (int i = 0; i < M * K; i++) r[i*DI +: DI] = DI'(v);
    return r;
  endfunction

  function automatic logic [BW-1:0] uni_b(input int v);
    logic [BW-1:0] r;
    for (int i = 0; i < N * K; i++) r[i*DI +: DI] = DI'(v);
    return r;
  endfunction

  function automatic logic [AW-1:0] pat_a(input int seed);
    logic [AW-1:0] r;
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++) r[(m*K+k)*DI +: DI] = DI'(((m*3 + k*5 + seed) % 11) - 5);
    return r;
  endfunction

  function automatic logic [BW-1:0] pat_b(input int seed);
    logic [BW-1:0] r;
    for (int n = 0; n < N; n++)
      for (int k = 0; k < K; k++) r[(n*K+k)*DI +: DI] = DI'(((n*7 + k*2 + seed) % 9) - 4);
    return r;
  endfunction

  // Plain matrix product; B is stored transposed, element n*K+k.
  task automatic add_ref(input logic [AW-1:0] a, input logic [BW-1:0] b);
    int s, av, bv;
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++) begin
        s = 0;
        for (int k = 0; k < K; k++) begin
          av = int'($signed(a[(m*K+k)*DI +: DI]));
          bv = int'($signed(b[(n*K+k)*DI +: DI]));
          s  = s + av * bv;
        end
        exp_c[m*N+n] = exp_c[m*N+n] + s;
      end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic last);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL push_accept observed=0 expected=1");
    end
  endtask

  task automatic get_tile(input string tag, input int exp_k);
    for (int n = 0; n < 60 && q_out.size() == 0; n++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    assert (q_out.size() != 0) else begin
      failures++;
      $error("FAIL %s_timeout observed=none expected=tile", tag);
    end
    if (q_out.size() != 0) begin
      chk(tag, q_out.pop_front(), pack_exp());
      chk({tag, "_kcnt"}, OW'(q_k.pop_front()), OW'(exp_k));
      void'(q_cyc.pop_front());
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", OW'(bus.out_valid), OW'(1'b0));
    chk("rst_out", bus.out, '0);
    chk("rst_kcnt", OW'(bus.out_kcnt), OW'(0));
    chk("rst_in_ready", OW'(bus.in_ready), OW'(1'b0));
    reset = 1'b1;
    #1;
    chk("run_in_ready", OW'(bus.in_ready), OW'(1'b1));
    @(posedge clk);
    #1;

    // Reset in the middle of a 3-beat stream discards everything in flight.
    repeat (3) push(uni_a(1), uni_b(1), 1'b0);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_in_ready", OW'(bus.in_ready), OW'(1'b0));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("midrst_no_tile", OW'(q_out.size()), OW'(0));
    chk("midrst_out_valid", OW'(bus.out_valid), OW'(1'b0));

    // Single beat A=1, B=2: C=16 three cycles after acceptance.
    set_uniform(16);
    push(uni_a(1), uni_b(2), 1'b1);
    @(posedge clk);
    #1;
    chk("lat_c2_valid", OW'(bus.out_valid), OW'(1'b0));
    @(posedge clk);
    #1;
    chk("lat_c3_valid", OW'(bus.out_valid), OW'(1'b1));
    chk("lat_c3_out", bus.out, pack_exp());
    chk("lat_c3_kcnt", OW'(bus.out_kcnt), OW'(1));
    get_tile("single", 1);

    // Four beats of A=1,B=3 then a new tile on the very next cycle.
    t0 = cyc;
    push(uni_a(1), uni_b(3), 1'b0);
    push(uni_a(1), uni_b(3), 1'b0);
    push(uni_a(1), uni_b(3), 1'b0);
    push(uni_a(1), uni_b(3), 1'b1);
    push(uni_a(1), uni_b(1), 1'b1);
    chk("b2b_accept_cycles", OW'(cyc - t0), OW'(5));
    for (int n = 0; n < 20 && q_out.size() < 2; n++) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_gap", OW'(q_cyc[1] - q_cyc[0]), OW'(1));
    set_uniform(96);
    get_tile("b2b_first", 4);
    set_uniform(8);
    get_tile("b2b_second", 1);

    // Back-pressure: result held 5 cycles while a 3-beat stream is pending.
    bus.out_ready = 1'b0;
    push(uni_a(1), uni_b(1), 1'b1);
    push(uni_a(1), uni_b(2), 1'b0);
    push(uni_a(1), uni_b(2), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_a     = uni_a(1);
    bus.in_b     = uni_b(2);
    bus.in_last  = 1'b1;
    set_uniform(8);
    repeat (5) begin
      #1;
      chk("bp_in_ready", OW'(bus.in_ready), OW'(1'b0));
      chk("bp_out_valid", OW'(bus.out_valid), OW'(1'b1));
      chk("bp_out_stable", bus.out, pack_exp());
      @(posedge clk);
      #1;
    end
    chk("bp_no_handshake", OW'(q_out.size()), OW'(0));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    get_tile("bp_held", 1);
    set_uniform(48);
    get_tile("bp_next", 3);

    // 17 beats with no early last: forced close at 16, beat 17 alone.
    repeat (16) push(uni_a(1), uni_b(1), 1'b0);
    push(uni_a(1), uni_b(1), 1'b1);
    set_uniform(128);
    get_tile("kstep_full", 16);
    set_uniform(8);
    get_tile("kstep_next", 1);

    // Large accumulations: output conversion at both signed extremes.
    repeat (16) push(uni_a(127), uni_b(127), 1'b0);
    set_uniform(127 * 127 * 8 * 16);
    get_tile("big_pos", 16);
    repeat (16) push(uni_a(-128), uni_b(127), 1'b0);
    set_uniform(-128 * 127 * 8 * 16);
    get_tile("big_neg", 16);

    // Mixed-sign, element-distinct operands checked against the matrix model.
    set_uniform(0);
    add_ref(pat_a(1), pat_b(1));
    add_ref(pat_a(2), pat_b(2));
    push(pat_a(1), pat_b(1), 1'b0);
    push(pat_a(2), pat_b(2), 1'b1);
    get_tile("mixed_2beat", 2);
    set_uniform(0);
    add_ref(pat_a(3), pat_b(7));
    push(pat_a(3), pat_b(7), 1'b1);
    get_tile("mixed_1beat", 1);

    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("no_extra_tiles", OW'(q_out.size()), OW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
